// File: rtl/uart_ctrl.sv
// Byte-wide strobe controller for the external UART sharing the RAM1 data bus.
// Status pins are double-flopped; strobes and bus enable decode from state.
module uart_ctrl #(
    parameter int RD_PULSE   = 2,
    parameter int WR_PULSE   = 2,
    parameter int SYNC_GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       tx_ready,
    output logic       rx_ready,
    input  logic [7:0] uart_din,
    output logic [7:0] uart_dout,
    output logic       uart_doe,
    output logic       rdn,
    output logic       wrn,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre
);

    typedef enum logic [3:0] {
        IDLE,
        RD_WAIT,
        RD_LOW,
        RD_REC,
        WR_SETUP,
        WR_LOW,
        WR_HOLD,
        WR_TBRE,
        WR_TSRE,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] r_rdata;
    logic [7:0] r_dout;
    logic       r_dr_m;
    logic       r_dr_s;
    logic       r_tbre_m;
    logic       r_tbre_s;
    logic       r_tsre_m;
    logic       r_tsre_s;
    logic       w_rd_last;
    logic       w_wr_last;
    logic       w_rec_last;
    logic       w_guard_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dr_m   <= 1'b0;
            r_dr_s   <= 1'b0;
            r_tbre_m <= 1'b0;
            r_tbre_s <= 1'b0;
            r_tsre_m <= 1'b0;
            r_tsre_s <= 1'b0;
        end else begin
            r_dr_m   <= data_ready;
            r_dr_s   <= r_dr_m;
            r_tbre_m <= tbre;
            r_tbre_s <= r_tbre_m;
            r_tsre_m <= tsre;
            r_tsre_s <= r_tsre_m;
        end
    end

    // r_cnt counts cycles spent in the current state, saturating
    assign w_rd_last  = (r_cnt == 8'(RD_PULSE - 1));
    assign w_wr_last  = (r_cnt == 8'(WR_PULSE - 1));
    assign w_rec_last = (r_cnt == 8'(SYNC_GUARD - 1));
    assign w_guard_ok = (r_cnt >= 8'(SYNC_GUARD - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = we ? WR_SETUP : RD_WAIT;
                end
            end
            RD_WAIT:  if (r_dr_s) w_next = RD_LOW;
            RD_LOW:   if (w_rd_last) w_next = RD_REC;
            RD_REC:   if (w_rec_last) w_next = DONE;
            WR_SETUP: w_next = WR_LOW;
            WR_LOW:   if (w_wr_last) w_next = WR_HOLD;
            WR_HOLD:  w_next = WR_TBRE;
            WR_TBRE:  if (w_guard_ok && r_tbre_s) w_next = WR_TSRE;
            WR_TSRE:  if (r_tsre_s) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rdata <= 8'd0;
            r_dout  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == RD_LOW && w_rd_last) begin
                r_rdata <= uart_din;
            end
            if (r_state == IDLE && req && we) begin
                r_dout <= wdata;
            end
        end
    end

    assign rdata     = r_rdata;
    assign uart_dout = r_dout;
    assign rdn       = (r_state != RD_LOW);
    assign wrn       = (r_state != WR_LOW);
    assign uart_doe  = (r_state == WR_SETUP) ||
                       (r_state == WR_LOW)   ||
                       (r_state == WR_HOLD);
    assign ack       = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign tx_ready  = r_tbre_s & r_tsre_s;
    assign rx_ready  = r_dr_s;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl; ack events are matched against a queue of
// expected completions (cycle and read byte) pushed when requests are issued.
module tb_uart_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic       tx_ready;
    logic       rx_ready;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       uart_doe;
    logic       rdn;
    logic       wrn;
    logic       data_ready;
    logic       tbre;
    logic       tsre;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    uart_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .busy      (busy),
        .tx_ready  (tx_ready),
        .rx_ready  (rx_ready),
        .uart_din  (uart_din),
        .uart_dout (uart_dout),
        .uart_doe  (uart_doe),
        .rdn       (rdn),
        .wrn       (wrn),
        .data_ready(data_ready),
        .tbre      (tbre),
        .tsre      (tsre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input bit is_rd, input logic [7:0] d, input int lat);
        exp_t e;
        e.is_rd = is_rd;
        e.data  = d;
        e.cyc   = cyc + 1 + lat;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ack === 1'b1) begin
            if (sbq.size() == 0) begin
                chk1("ack_unexpected", ack, 1'b0);
            end else begin
                e = sbq.pop_front();
                chki("ack_cycle", cyc, e.cyc);
                if (e.is_rd) chk8("ack_rdata", rdata, e.data);
            end
        end
    endtask

    initial begin
        cyc        = 0;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        wdata      = 8'h00;
        uart_din   = 8'h00;
        data_ready = 1'b0;
        tbre       = 1'b0;
        tsre       = 1'b0;

        // reset values
        #3;
        chk1("rst_rdn", rdn, 1'b1);
        chk1("rst_wrn", wrn, 1'b1);
        chk1("rst_doe", uart_doe, 1'b0);
        chk8("rst_dout", uart_dout, 8'h00);
        chk8("rst_rdata", rdata, 8'h00);
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_txr", tx_ready, 1'b0);
        chk1("rst_rxr", rx_ready, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // idle polling: 2-cycle status latency
        tbre       = 1'b1;
        tsre       = 1'b0;
        data_ready = 1'b1;
        tick();
        chk1("poll_rxr_1", rx_ready, 1'b0);
        tick();
        chk1("poll_rxr_2", rx_ready, 1'b1);
        chk1("poll_txr_2", tx_ready, 1'b0);
        chk1("poll_busy", busy, 1'b0);
        chk1("poll_rdn", rdn, 1'b1);
        chk1("poll_wrn", wrn, 1'b1);
        tsre = 1'b1;
        tick();
        tick();
        chk1("poll_txr_up", tx_ready, 1'b1);

        // write 0xA5 with all status high
        wdata = 8'hA5;
        we    = 1'b1;
        req   = 1'b1;
        push(1'b0, 8'h00, 7);
        tick();
        req   = 1'b0;
        wdata = 8'h00;
        chk1("wr_c0_doe", uart_doe, 1'b1);
        chk8("wr_c0_dout", uart_dout, 8'hA5);
        chk1("wr_c0_wrn", wrn, 1'b1);
        chk1("wr_c0_busy", busy, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk1("wr_doe", uart_doe, c <= 3);
            chk1("wr_wrn", wrn, !(c == 1 || c == 2));
            chk1("wr_rdn", rdn, 1'b1);
            chk1("wr_ack", ack, c == 7);
            chk1("wr_busy", busy, c <= 7);
            if (c <= 3) chk8("wr_dout", uart_dout, 8'hA5);
        end

        // read with data_ready low, raised 6 cycles later
        data_ready = 1'b0;
        tick();
        tick();
        tick();
        chk1("rd_rxr_low", rx_ready, 1'b0);
        uart_din = 8'h3C;
        we       = 1'b0;
        req      = 1'b1;
        push(1'b1, 8'h3C, 13);
        tick();
        req = 1'b0;
        chk1("rd_c0_rdn", rdn, 1'b1);
        chk1("rd_c0_busy", busy, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk1("rd_rdn", rdn, !(c == 9 || c == 10));
            chk1("rd_wrn", wrn, 1'b1);
            chk1("rd_doe", uart_doe, 1'b0);
            chk1("rd_ack", ack, c == 13);
            chk1("rd_rxr", rx_ready, c >= 8);
            if (c == 10) chk8("rd_rdata_old", rdata, 8'h00);
            if (c == 11) chk8("rd_rdata_new", rdata, 8'h3C);
            if (c == 6) data_ready = 1'b1;
        end

        // back-to-back reads with req held high
        uart_din = 8'h11;
        we       = 1'b0;
        req      = 1'b1;
        push(1'b1, 8'h11, 5);
        tick();
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk1("b2b_rdn", rdn,
                 !(c == 1 || c == 2 || c == 15 || c == 16));
            chk1("b2b_ack", ack, c == 5 || c == 19);
            chk1("b2b_busy", busy, !(c == 6 || c == 20));
            if (c == 16) chk8("b2b_rdata_1", rdata, 8'h11);
            if (c == 17) chk8("b2b_rdata_2", rdata, 8'h22);
            if (c == 4) data_ready = 1'b0;
            if (c == 6) push(1'b1, 8'h22, 12);
            if (c == 7) req = 1'b0;
            if (c == 12) begin
                data_ready = 1'b1;
                uart_din   = 8'h22;
            end
        end

        // write stalled by tbre/tsre
        wdata = 8'h3F;
        we    = 1'b1;
        req   = 1'b1;
        push(1'b0, 8'h00, 22);
        tick();
        req = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            tick();
            chk1("stl_wrn", wrn, !(c == 1 || c == 2));
            chk1("stl_doe", uart_doe, c <= 3);
            chk1("stl_ack", ack, c == 22);
            chk1("stl_busy", busy, c <= 22);
            chk1("stl_txr", tx_ready, c < 6 || c >= 21);
            if (c == 4) begin
                tbre = 1'b0;
                tsre = 1'b0;
            end
            if (c == 14) tbre = 1'b1;
            if (c == 19) tsre = 1'b1;
        end

        // asynchronous reset during WR_LOW
        chk8("pre_rst_rdata", rdata, 8'h22);
        wdata = 8'h5A;
        we    = 1'b1;
        req   = 1'b1;
        tick();
        req = 1'b0;
        tick();
        chk1("mid_wrn_low", wrn, 1'b0);
        chk1("mid_doe_hi", uart_doe, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("mid_rst_wrn", wrn, 1'b1);
        chk1("mid_rst_doe", uart_doe, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ack", ack, 1'b0);
        chk8("mid_rst_rdata", rdata, 8'h00);
        chk8("mid_rst_dout", uart_dout, 8'h00);
        tick();
        chk1("mid_rst_ack2", ack, 1'b0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("post_rst_busy", busy, 1'b0);
            chk1("post_rst_ack", ack, 1'b0);
            chk1("post_rst_wrn", wrn, 1'b1);
            chk1("post_rst_rdn", rdn, 1'b1);
        end

        chki("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
